sr_lsu: RTL and testbench

Load/store unit for the single-cycle schoolRISCV core. Sits directly downstream of the control decoder (`dmWe`, `dmSign`, `dmOpByte/Half/Word`, `memToReg`) and the ALU (effective address). It converts each load/store into one word-aligned request on a valid/ack data bus, stalls the core until the bus completes, and returns the load result lane-extracted and sign- or zero-extended to the register-file write-back mux.

---
 rtl/sr_lsu_pkg.sv | 31 +++
 rtl/sr_lsu_align.sv | 47 ++++
 rtl/sr_lsu.sv | 142 ++++++++++++++
 tb/tb_sr_lsu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_lsu_pkg.sv
// rtl/sr_lsu_pkg.sv - shared access-size and FSM state encodings for the load/store unit
package sr_lsu_pkg;

    typedef enum logic [1:0] {
        DM_BYTE = 2'd0,
        DM_HALF = 2'd1,
        DM_WORD = 2'd2
    } dmMode_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsuState_t;

    // Any mode that is not cleanly one-hot falls back to a full word access.
    function automatic dmMode_t decodeMode(input logic opByte, input logic opHalf, input logic opWord);
        dmMode_t m;
        if (opWord) begin
            m = DM_WORD;
        end else begin
            case ({opByte, opHalf})
                2'b10:   m = DM_BYTE;
                2'b01:   m = DM_HALF;
                default: m = DM_WORD;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/sr_lsu_align.sv
// rtl/sr_lsu_align.sv - byte-lane formatting for stores and extraction/extension for loads
module sr_lsu_align
    import sr_lsu_pkg::*;
(
    input  dmMode_t     mode,
    input  logic [1:0]  addrLo,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdataLane,
    output logic [31:0] rdataExt,
    output logic        misalign
);

    logic [31:0] shifted;

    // Lane selection, replication, extension and alignment check per access size
    always_comb begin
        shifted   = rdata >> {addrLo, 3'b000};
        be        = 4'b1111;
        wdataLane = wdata;
        rdataExt  = shifted;
        misalign  = 1'b0;
        case (mode)
            DM_BYTE: begin
                be        = 4'b0001 << addrLo;
                wdataLane = {4{wdata[7:0]}};
                rdataExt  = {{24{sign & shifted[7]}}, shifted[7:0]};
                misalign  = 1'b0;
            end
            DM_HALF: begin
                be        = addrLo[1] ? 4'b1100 : 4'b0011;
                wdataLane = {2{wdata[15:0]}};
                rdataExt  = {{16{sign & shifted[15]}}, shifted[15:0]};
                misalign  = addrLo[0];
            end
            default: begin
                be        = 4'b1111;
                wdataLane = wdata;
                rdataExt  = shifted;
                misalign  = |addrLo;
            end
        endcase
    end

endmodule

// File: rtl/sr_lsu.sv
// rtl/sr_lsu.sv - load/store unit: one word-aligned bus request per access, core stalled until done
module sr_lsu
    import sr_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        dmWe,
    input  logic        dmSign,
    input  logic        dmOpByte,
    input  logic        dmOpHalf,
    input  logic        dmOpWord,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] lsuRdata,
    output logic        lsuMisalign,
    output logic        lsuErr,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [3:0]  busBe,
    output logic [31:0] busWdata,
    input  logic        busAck,
    input  logic [31:0] busRdata
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    lsuState_t   state;
    logic [7:0]  waitCnt;
    dmMode_t     modeQ;
    logic [1:0]  addrLoQ;
    logic        signQ;
    logic        weQ;

    logic        memOp;
    dmMode_t     modeIn;
    dmMode_t     alignMode;
    logic [1:0]  alignAddrLo;
    logic        alignSign;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata;
    logic [31:0] alignRdata;
    logic        alignMisalign;

    assign memOp  = memRead | dmWe;
    assign modeIn = decodeMode(dmOpByte, dmOpHalf, dmOpWord);
    assign stall  = memOp & (state != LSU_DONE) & ~rst;

    // While a request is outstanding the aligner works on the latched access, otherwise on the incoming one
    assign alignMode   = (state == LSU_REQ) ? modeQ   : modeIn;
    assign alignAddrLo = (state == LSU_REQ) ? addrLoQ : addr[1:0];
    assign alignSign   = (state == LSU_REQ) ? signQ   : dmSign;

    sr_lsu_align u_align (
        .mode      (alignMode),
        .addrLo    (alignAddrLo),
        .sign      (alignSign),
        .wdata     (wdata),
        .rdata     (busRdata),
        .be        (alignBe),
        .wdataLane (alignWdata),
        .rdataExt  (alignRdata),
        .misalign  (alignMisalign)
    );

    // Access sequencer: latch in IDLE, hold the bus in REQ until ack or timeout, report for one cycle in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LSU_IDLE;
            waitCnt     <= 8'd0;
            modeQ       <= DM_WORD;
            addrLoQ     <= 2'b00;
            signQ       <= 1'b0;
            weQ         <= 1'b0;
            busReq      <= 1'b0;
            busWe       <= 1'b0;
            busAddr     <= 32'd0;
            busBe       <= 4'd0;
            busWdata    <= 32'd0;
            lsuRdata    <= 32'd0;
            lsuErr      <= 1'b0;
            lsuMisalign <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    lsuErr      <= 1'b0;
                    lsuMisalign <= 1'b0;
                    if (memOp) begin
                        modeQ    <= modeIn;
                        addrLoQ  <= addr[1:0];
                        signQ    <= dmSign;
                        weQ      <= dmWe;
                        waitCnt  <= 8'd0;
                        lsuRdata <= 32'd0;
                        if (alignMisalign) begin
                            lsuMisalign <= 1'b1;
                            state       <= LSU_DONE;
                        end else begin
                            busReq   <= 1'b1;
                            busWe    <= dmWe;
                            busAddr  <= {addr[31:2], 2'b00};
                            busBe    <= alignBe;
                            busWdata <= alignWdata;
                            state    <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (busAck || (waitCnt == WAIT_LAST)) begin
                        busReq   <= 1'b0;
                        busWe    <= 1'b0;
                        busAddr  <= 32'd0;
                        busBe    <= 4'd0;
                        busWdata <= 32'd0;
                        state    <= LSU_DONE;
                        if (busAck) begin
                            lsuRdata <= weQ ? 32'd0 : alignRdata;
                        end else begin
                            lsuRdata <= 32'd0;
                            lsuErr   <= 1'b1;
                        end
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                LSU_DONE: begin
                    lsuErr      <= 1'b0;
                    lsuMisalign <= 1'b0;
                    state       <= LSU_IDLE;
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_lsu.sv
// tb/tb_sr_lsu.sv - self-checking bench for sr_lsu with a byte-arithmetic reference model
module tb_sr_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b0;
    logic        dmWe = 1'b0;
    logic        dmSign = 1'b0;
    logic        dmOpByte = 1'b0;
    logic        dmOpHalf = 1'b0;
    logic        dmOpWord = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall;
    logic [31:0] lsuRdata;
    logic        lsuMisalign;
    logic        lsuErr;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [3:0]  busBe;
    logic [31:0] busWdata;
    logic        busAck = 1'b0;
    logic [31:0] busRdata = 32'd0;

    int checks = 0;
    int failures = 0;

    sr_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .dmWe(dmWe), .dmSign(dmSign),
        .dmOpByte(dmOpByte), .dmOpHalf(dmOpHalf), .dmOpWord(dmOpWord),
        .addr(addr), .wdata(wdata), .stall(stall), .lsuRdata(lsuRdata),
        .lsuMisalign(lsuMisalign), .lsuErr(lsuErr), .busReq(busReq), .busWe(busWe),
        .busAddr(busAddr), .busBe(busBe), .busWdata(busWdata),
        .busAck(busAck), .busRdata(busRdata)
    );

    always #5 clk = ~clk;

    function automatic int sizeOf(input logic [2:0] bhw);
        if (bhw == 3'b100) return 1;
        if (bhw == 3'b010) return 2;
        return 4;
    endfunction

    // One complete access; ackDelay < 0 means the bus never answers
    task automatic doAccess(input string tag, input bit isLoad, input bit sgn, input logic [2:0] bhw,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdWord,
                            input int ackDelay, output logic [3:0] gotBe, output logic [31:0] gotWdata,
                            output logic [31:0] gotRdata);
        int nb;
        int lane;
        int beInt;
        bit mis;
        bit timedOut;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
        logic [31:0] mask;
        logic [31:0] val;
        nb       = sizeOf(bhw);
        lane     = int'(a % 4);
        mis      = (a % nb) != 0;
        timedOut = (ackDelay < 0);
        beInt    = ((1 << nb) - 1) << lane;
        expBe    = beInt[3:0];
        for (int i = 0; i < 4; i++) expWdata[8*i +: 8] = wd[8*(i % nb) +: 8];
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        val  = (rdWord >> (8*lane)) & mask;
        if (sgn && val[8*nb-1]) val = val | ~mask;
        expRdata = (mis || timedOut || !isLoad) ? 32'd0 : val;
        gotBe    = 4'd0;
        gotWdata = 32'd0;

        @(negedge clk);
        memRead = isLoad; dmWe = !isLoad; dmSign = sgn;
        {dmOpByte, dmOpHalf, dmOpWord} = bhw;
        addr = a; wdata = wd; busAck = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL %s idle_stall got=%b exp=1", tag, stall); end
        checks++; if (busReq !== 1'b0) begin failures++; $display("FAIL %s idle_busReq got=%b exp=0", tag, busReq); end
        @(negedge clk);
        if (!mis) begin
            for (int w = 0; w < TO; w++) begin
                checks++; if (busReq !== 1'b1) begin failures++; $display("FAIL %s req_busReq w=%0d got=%b exp=1", tag, w, busReq); end
                checks++; if (stall !== 1'b1) begin failures++; $display("FAIL %s req_stall w=%0d got=%b exp=1", tag, w, stall); end
                checks++; if (busAddr !== {a[31:2], 2'b00}) begin failures++; $display("FAIL %s busAddr got=%h exp=%h", tag, busAddr, {a[31:2], 2'b00}); end
                checks++; if (busBe !== expBe) begin failures++; $display("FAIL %s busBe got=%b exp=%b", tag, busBe, expBe); end
                checks++; if (busWe !== !isLoad) begin failures++; $display("FAIL %s busWe got=%b exp=%b", tag, busWe, !isLoad); end
                if (!isLoad) begin
                    checks++; if (busWdata !== expWdata) begin failures++; $display("FAIL %s busWdata got=%h exp=%h", tag, busWdata, expWdata); end
                end
                if (w == 0) begin gotBe = busBe; gotWdata = busWdata; end
                if (!timedOut && w == ackDelay) begin
                    busAck = 1'b1; busRdata = rdWord;
                    @(negedge clk);
                    busAck = 1'b0; busRdata = $urandom;
                    break;
                end
                busAck = 1'b0; busRdata = $urandom;
                @(negedge clk);
            end
        end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL %s done_stall got=%b exp=0", tag, stall); end
        checks++; if (busReq !== 1'b0) begin failures++; $display("FAIL %s done_busReq got=%b exp=0", tag, busReq); end
        checks++; if (lsuMisalign !== mis) begin failures++; $display("FAIL %s lsuMisalign got=%b exp=%b", tag, lsuMisalign, mis); end
        checks++; if (lsuErr !== (timedOut && !mis)) begin failures++; $display("FAIL %s lsuErr got=%b exp=%b", tag, lsuErr, timedOut && !mis); end
        checks++; if (lsuRdata !== expRdata) begin failures++; $display("FAIL %s lsuRdata got=%h exp=%h", tag, lsuRdata, expRdata); end
        gotRdata = lsuRdata;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        memRead = 1'b0; dmWe = 1'b0; busAck = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; memRead = 1'b1; dmOpWord = 1'b1; addr = 32'h100;
        @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if ({busReq, busWe, busBe} !== 6'd0) begin failures++; $display("FAIL reset_bus_ctl got=%b exp=0", {busReq, busWe, busBe}); end
        checks++; if ({busAddr, busWdata} !== 64'd0) begin failures++; $display("FAIL reset_bus_data got=%h exp=0", {busAddr, busWdata}); end
        checks++; if ({lsuRdata, lsuErr, lsuMisalign} !== 34'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", {lsuRdata, lsuErr, lsuMisalign}); end
        @(negedge clk);
        rst = 1'b0; memRead = 1'b0;
    endtask

    task automatic test_ack_ignored();
        @(negedge clk);
        busAck = 1'b1; busRdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (busReq !== 1'b0) begin failures++; $display("FAIL stray_ack_busReq got=%b exp=0", busReq); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stray_ack_stall got=%b exp=0", stall); end
        busAck = 1'b0;
    endtask

    task automatic test_store();
        logic [3:0] be; logic [31:0] wd, rd;
        doAccess("sw", 1'b0, 1'b0, 3'b001, 32'h104, 32'hDEAD_BEEF, $urandom, 0, be, wd, rd);
        checks++; if (be !== 4'b1111) begin failures++; $display("FAIL sw_be got=%b exp=1111", be); end
        checks++; if (wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", wd); end
        doAccess("sb", 1'b0, 1'b0, 3'b100, 32'h203, 32'h0000_00A5, $urandom, 1, be, wd, rd);
        checks++; if (be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", be); end
        checks++; if (wd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", wd); end
        idleCycle();
    endtask

    task automatic test_loads();
        logic [3:0] be; logic [31:0] wd, rd;
        doAccess("lb", 1'b1, 1'b1, 3'b100, 32'h2, 32'd0, 32'h0080_FF00, 0, be, wd, rd);
        checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_value got=%h exp=ffffff80", rd); end
        doAccess("lbu", 1'b1, 1'b0, 3'b100, 32'h2, 32'd0, 32'h0080_FF00, 2, be, wd, rd);
        checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL lbu_value got=%h exp=00000080", rd); end
        doAccess("lh", 1'b1, 1'b1, 3'b010, 32'h2, 32'd0, 32'h8001_0000, 0, be, wd, rd);
        checks++; if (rd !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_value got=%h exp=ffff8001", rd); end
        idleCycle();
    endtask

    task automatic test_misalign();
        logic [3:0] be; logic [31:0] wd, rd;
        doAccess("lw_mis", 1'b1, 1'b0, 3'b001, 32'h6, 32'd0, 32'h1234_5678, 0, be, wd, rd);
        doAccess("sh_mis", 1'b0, 1'b0, 3'b010, 32'h11, 32'h5555, 32'd0, 0, be, wd, rd);
        idleCycle();
    endtask

    task automatic test_timeout();
        logic [3:0] be; logic [31:0] wd, rd;
        doAccess("lw_timeout", 1'b1, 1'b1, 3'b001, 32'h80, 32'd0, 32'hFFFF_FFFF, -1, be, wd, rd);
        idleCycle();
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        memRead = 1'b1; dmWe = 1'b0; {dmOpByte, dmOpHalf, dmOpWord} = 3'b001; addr = 32'h40;
        @(negedge clk);
        checks++; if (busReq !== 1'b1) begin failures++; $display("FAIL rstmid_req got=%b exp=1", busReq); end
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall_in_rst got=%b exp=0", stall); end
        @(negedge clk);
        rst = 1'b0; memRead = 1'b0; busAck = 1'b1; busRdata = 32'h1234_5678;
        #1;
        checks++; if (busReq !== 1'b0) begin failures++; $display("FAIL rstmid_busReq got=%b exp=0", busReq); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
        @(negedge clk);
        busAck = 1'b0;
        checks++; if ({busReq, lsuErr, lsuMisalign} !== 3'b000) begin failures++; $display("FAIL rstmid_flags got=%b exp=000", {busReq, lsuErr, lsuMisalign}); end
        checks++; if (lsuRdata !== 32'd0) begin failures++; $display("FAIL rstmid_rdata got=%h exp=0", lsuRdata); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] modes [6] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b110, 3'b111};
        logic [3:0] be; logic [31:0] wd, rd, a;
        int d;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            d = $urandom_range(0, 4);
            if (d == 4) d = -1;
            doAccess("rand", 1'($urandom), 1'($urandom), modes[$urandom_range(0, 5)], a,
                     $urandom, $urandom, d, be, wd, rd);
            if ($urandom_range(0, 3) == 0) idleCycle();
        end
        idleCycle();
    endtask

    initial begin
        test_reset();
        test_ack_ignored();
        test_store();
        test_loads();
        test_misalign();
        test_timeout();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
